// File: rtl/custom_fifo_pkg.sv
// Shared constants for the byte-to-word packing FIFO: default geometry and
// the counter/pointer widths derived from it.
package custom_fifo_pkg;

  localparam int DEF_IN_DATA_WIDTH  = 8;
  localparam int DEF_OUT_DATA_WIDTH = 32;
  localparam int DEF_DEPTH          = 8;
  localparam int DEF_PACKET_WORDS   = 8;

  // Bits needed to hold numStates distinct values, never less than one bit.
  function automatic int widthFor(input int numStates);
    return (numStates <= 2) ? 1 : $clog2(numStates);
  endfunction

  localparam int DEF_PTR_WIDTH   = widthFor(DEF_DEPTH);
  localparam int DEF_COUNT_WIDTH = widthFor(DEF_DEPTH + 1);
  localparam int DEF_BEAT_WIDTH  = widthFor(DEF_OUT_DATA_WIDTH / DEF_IN_DATA_WIDTH);
  localparam int DEF_PKT_WIDTH   = widthFor(DEF_PACKET_WORDS);

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head word is visible on
// data_o as soon as it is stored, and reads as zero while empty.
module sync_fifo_fwft
  import custom_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = widthFor(DEPTH);
  localparam int CNT_W = widthFor(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is left uncleared on reset; the zeroed count hides stale words.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/custom_fifo.sv
// Packs narrow slave beats little-endian into wide words, buffers them in a
// FWFT FIFO and frames the master stream into fixed-length TLAST packets.
module custom_fifo
  import custom_fifo_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int PACKET_WORDS   = DEF_PACKET_WORDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axis_tvalid,
  input  logic [IN_DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [OUT_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);

  localparam int RATIO  = OUT_DATA_WIDTH / IN_DATA_WIDTH;
  localparam int BEAT_W = widthFor(RATIO);
  localparam int PKT_W  = widthFor(PACKET_WORDS);

  logic [BEAT_W-1:0]         beatCnt_q, beatCnt_d;
  logic [OUT_DATA_WIDTH-1:0] packReg_q, packReg_d;
  logic [PKT_W-1:0]          pktCnt_q, pktCnt_d;
  logic [OUT_DATA_WIDTH-1:0] packedWord;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic                      slaveHs;
  logic                      masterHs;
  logic                      wordDone;

  assign s_axis_tready = rst_n && !fifoFull;
  assign m_axis_tvalid = !fifoEmpty;
  assign m_axis_tlast  = m_axis_tvalid && (pktCnt_q == PKT_W'(PACKET_WORDS - 1));
  assign slaveHs       = s_axis_tvalid && s_axis_tready;
  assign masterHs      = m_axis_tvalid && m_axis_tready;
  assign wordDone      = slaveHs && (beatCnt_q == BEAT_W'(RATIO - 1));

  // Merge the incoming beat into its lane so the final beat can be pushed
  // straight into the FIFO on the same edge it is accepted.
  always_comb begin
    packedWord = packReg_q;
    for (int k = 0; k < RATIO; k++) begin
      if (beatCnt_q == BEAT_W'(k)) begin
        packedWord[IN_DATA_WIDTH*k +: IN_DATA_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_comb begin
    beatCnt_d = beatCnt_q;
    packReg_d = packReg_q;
    pktCnt_d  = pktCnt_q;
    if (slaveHs) begin
      if (wordDone) begin
        beatCnt_d = '0;
        packReg_d = '0;
      end else begin
        beatCnt_d = beatCnt_q + BEAT_W'(1);
        packReg_d = packedWord;
      end
    end
    if (masterHs) begin
      pktCnt_d = (pktCnt_q == PKT_W'(PACKET_WORDS - 1)) ? '0 : pktCnt_q + PKT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beatCnt_q <= '0;
      packReg_q <= '0;
      pktCnt_q  <= '0;
    end else begin
      beatCnt_q <= beatCnt_d;
      packReg_q <= packReg_d;
      pktCnt_q  <= pktCnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (wordDone),
    .data_i  (packedWord),
    .pop_i   (masterHs),
    .data_o  (m_axis_tdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule

// File: tb/tb_custom_fifo.sv
// Directed self-checking bench for custom_fifo: packing, fill, drain,
// concurrent push/pop across wrap, back-pressure and mid-stream reset.
module tb_custom_fifo;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata  = '0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  int checksRun     = 0;
  int checksPassed  = 0;
  int bytesAccepted = 0;
  int popIdx        = 0;
  int guard         = 0;
  int bpIdx         = 0;

  logic [7:0]  packBytes  [11] = '{8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'hFF, 8'hBB, 8'hBB, 8'hBB, 8'hBB};
  logic [31:0] drainWords [8]  = '{32'hFFFF55AA, 32'hBBFFFFFF, 32'hBBBBBBBB, 32'hBBBBBBBB,
                                   32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB};
  logic [31:0] bpWords    [2]  = '{32'hA3A2A1A0, 32'hA7A6A5A4};
  logic        bpReady    [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  resetBytes [4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [31:0] expQ [$];
  logic [31:0] building;
  logic [7:0]  nextByte;

  custom_fifo #(
    .IN_DATA_WIDTH  (8),
    .OUT_DATA_WIDTH (32),
    .DEPTH          (8),
    .PACKET_WORDS   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksRun++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, so outputs read here are settled.
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic mReady);
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    m_axis_tready = mReady;
    if (valid && s_axis_tready) bytesAccepted++;
    if (m_axis_tvalid && mReady) popIdx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rstSReady", {31'b0, s_axis_tready}, 32'd0);
    checkOutput("rstMValid", {31'b0, m_axis_tvalid}, 32'd0);
    checkOutput("rstMData",  m_axis_tdata, 32'd0);
    checkOutput("rstMLast",  {31'b0, m_axis_tlast}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("relSReady", {31'b0, s_axis_tready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, packBytes[i], 1'b0);
      if (i == 2) checkOutput("packNotYet", {31'b0, m_axis_tvalid}, 32'd0);
      if (i == 3) begin
        checkOutput("packValid", {31'b0, m_axis_tvalid}, 32'd1);
        checkOutput("packWord0", m_axis_tdata, 32'hFFFF55AA);
      end
    end
    checkOutput("packHead", m_axis_tdata, 32'hFFFF55AA);

    guard = 0;
    while (s_axis_tready && guard < 100) begin
      applyStimulus(1'b1, 8'hBB, 1'b0);
      guard++;
    end
    checkOutput("fillBytes",  bytesAccepted, 32'd32);
    checkOutput("fillReady",  {31'b0, s_axis_tready}, 32'd0);
    checkOutput("fillValid",  {31'b0, m_axis_tvalid}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hCC, 1'b0);
    checkOutput("fullNoAcc",  bytesAccepted, 32'd32);
    checkOutput("fullValid",  {31'b0, m_axis_tvalid}, 32'd1);
    checkOutput("fullHead",   m_axis_tdata, 32'hFFFF55AA);

    for (int i = 0; i < 8; i++) begin
      checkOutput("drainValid", {31'b0, m_axis_tvalid}, 32'd1);
      checkOutput("drainData",  m_axis_tdata, drainWords[i]);
      checkOutput("drainLast",  {31'b0, m_axis_tlast}, (i == 7) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("emptyValid", {31'b0, m_axis_tvalid}, 32'd0);
    checkOutput("emptyData",  m_axis_tdata, 32'd0);
    checkOutput("emptyLast",  {31'b0, m_axis_tlast}, 32'd0);

    nextByte = 8'h01;
    for (int w = 0; w < 3; w++) begin
      building = '0;
      for (int k = 0; k < 4; k++) begin
        building[8*k +: 8] = nextByte;
        applyStimulus(1'b1, nextByte, 1'b0);
        nextByte++;
      end
      expQ.push_back(building);
    end
    for (int w = 0; w < 12; w++) begin
      building = '0;
      for (int k = 0; k < 4; k++) begin
        building[8*k +: 8] = nextByte;
        if (k == 3) begin
          checkOutput("simValid", {31'b0, m_axis_tvalid}, 32'd1);
          checkOutput("simData",  m_axis_tdata, expQ[0]);
          checkOutput("simLast",  {31'b0, m_axis_tlast}, ((popIdx % 8) == 7) ? 32'd1 : 32'd0);
          void'(expQ.pop_front());
          expQ.push_back(building);
        end
        applyStimulus(1'b1, nextByte, k == 3);
        nextByte++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("simTailValid", {31'b0, m_axis_tvalid}, 32'd1);
      checkOutput("simTailData",  m_axis_tdata, expQ[0]);
      checkOutput("simTailLast",  {31'b0, m_axis_tlast}, ((popIdx % 8) == 7) ? 32'd1 : 32'd0);
      void'(expQ.pop_front());
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("simEmpty", {31'b0, m_axis_tvalid}, 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpValid", {31'b0, m_axis_tvalid}, 32'd1);
      checkOutput("bpData",  m_axis_tdata, bpWords[bpIdx]);
      checkOutput("bpLast",  {31'b0, m_axis_tlast}, ((popIdx % 8) == 7) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 8'h00, bpReady[i]);
      if (bpReady[i]) bpIdx++;
    end
    checkOutput("bpEmpty", {31'b0, m_axis_tvalid}, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0);
    checkOutput("preRstValid", {31'b0, m_axis_tvalid}, 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midRstValid",  {31'b0, m_axis_tvalid}, 32'd0);
    checkOutput("midRstSReady", {31'b0, s_axis_tready}, 32'd0);
    checkOutput("midRstData",   m_axis_tdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, resetBytes[i], 1'b0);
      if (i == 2) checkOutput("postRstPartial", {31'b0, m_axis_tvalid}, 32'd0);
    end
    checkOutput("postRstValid", {31'b0, m_axis_tvalid}, 32'd1);
    checkOutput("postRstWord",  m_axis_tdata, 32'hDDCCBBAA);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule

// File: doc/custom_fifo.md
CUSTOM_FIFO -- requirements
Module: custom_fifo

Interface
REQ-001 The module SHALL have parameter IN_DATA_WIDTH, default 8, giving the slave beat width in bits.
REQ-002 The module SHALL have parameter OUT_DATA_WIDTH, default 32, giving the master beat width in bits; it is an integer multiple of IN_DATA_WIDTH, and RATIO = OUT_DATA_WIDTH/IN_DATA_WIDTH.
REQ-003 The module SHALL have parameter DEPTH, default 8, giving the number of OUT_DATA_WIDTH word entries; it is a power of two, at least 2.
REQ-004 The module SHALL have parameter PACKET_WORDS, default 8, giving the number of output words per TLAST-terminated packet; it is at least 1.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port s_axis_tvalid, input, 1 bit: slave beat valid.
REQ-008 The module SHALL have port s_axis_tdata, input, IN_DATA_WIDTH bits: slave beat data.
REQ-009 The module SHALL have port s_axis_tready, output, 1 bit: slave ready.
REQ-010 The module SHALL have port m_axis_tvalid, output, 1 bit: master beat valid.
REQ-011 The module SHALL have port m_axis_tdata, output, OUT_DATA_WIDTH bits: master beat data.
REQ-012 The module SHALL have port m_axis_tlast, output, 1 bit: last word of packet.
REQ-013 The module SHALL have port m_axis_tready, input, 1 bit: master ready.

Function
REQ-014 A slave handshake SHALL occur on a rising edge where s_axis_tvalid and s_axis_tready are both 1; a master handshake SHALL occur on a rising edge where m_axis_tvalid and m_axis_tready are both 1.
REQ-015 The packer SHALL place accepted bytes little-endian: beat k of a word (k = 0..RATIO-1) goes to bits [IN*(k+1)-1 : IN*k], so the first byte lands in the LSBs.
REQ-016 On the handshake of beat RATIO-1, the completed word SHALL be written into the FIFO on that same edge, and the beat counter SHALL return to 0.
REQ-017 The FIFO SHALL be first-word-fall-through: a word written on edge N is presented with m_axis_tvalid=1 from edge N onward (one cycle after the final byte), or behind the older words.
REQ-018 Occupancy SHALL be tracked as count 0..DEPTH; full = (count==DEPTH) and empty = (count==0).
REQ-019 s_axis_tready SHALL be 1 exactly when rst_n=1 and not full; when full, no byte is accepted, including partial-word bytes.
REQ-020 m_axis_tvalid SHALL equal not-empty, and m_axis_tdata SHALL be the head word, or all zeros when empty.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers advance.
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 A packet counter SHALL increment on each master handshake and wrap from PACKET_WORDS-1 to 0.
REQ-024 m_axis_tlast SHALL be 1 exactly when m_axis_tvalid=1 and the packet counter equals PACKET_WORDS-1.
REQ-025 Master outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 There SHALL be no overflow or underflow: push only when not full, and pop only when not empty.

Reset
REQ-027 While rst_n=0 at a rising edge, the module SHALL zero the count, pointers, beat counter, packet counter and packing register, discarding any partial word.
REQ-028 During and after reset, the outputs SHALL be m_axis_tvalid=0, m_axis_tlast=0 and m_axis_tdata=0; s_axis_tready SHALL be 0 while rst_n=0 and 1 after release.
REQ-029 A reset asserted mid-operation SHALL drop all stored data; FIFO memory contents need not be cleared.

Structure
REQ-030 A shared package custom_fifo_pkg SHALL hold the default width, depth and packet-length constants and the clog2-derived pointer and counter widths.
REQ-031 Storage SHALL sit in one sub-module, sync_fifo_fwft (parameters WIDTH and DEPTH); the packer and the TLAST counter SHALL reside in custom_fifo.

Verification
REQ-032 Bench SHALL cover packing: with m_axis_tready=0 after reset, drive bytes AA,55,FF,FF,FF,FF,FF,BB,BB,BB,BB -> words 0xFFFF55AA, 0xBBFFFFFF, with a third word 0xBBBBBBBB beginning.
REQ-033 Bench SHALL cover fill-to-full: hold s_axis_tvalid=1 with BB and m_axis_tready=0 -> after 32 bytes, count=8 and s_axis_tready=0, with no further bytes accepted and m_axis_tvalid held at 1.
REQ-034 Bench SHALL cover drain: set s_axis_tvalid=0 and m_axis_tready=1 -> 8 words out in order, m_axis_tlast=1 only on the 8th, then m_axis_tvalid=0 and m_axis_tdata=0.
REQ-035 Bench SHALL cover simultaneous operation: with the FIFO holding 3 words, stream bytes while m_axis_tready=1 -> occupancy steady, data order preserved, and tlast every 8th word across pointer wrap.
REQ-036 Bench SHALL cover back-pressure: toggle m_axis_tready with tvalid=1 -> tdata and tlast stable while stalled.
REQ-037 Bench SHALL cover mid-reset: pull rst_n low after 2 bytes and 1 full word -> next cycle tvalid=0 and tready=0; after release, a new byte AA begins a fresh word at bits [7:0].
